// File: rtl/fc_layer_seq_if.sv
// Handshake, coefficient-write and result bundle for the serial fully-connected layer.
interface fc_layer_seq_if #(
   parameter int DATA_W  = 16,
   parameter int NUM_IN  = 84,
   parameter int NUM_OUT = 10
);
   localparam int WA_W = $clog2(NUM_IN*NUM_OUT);
   localparam int BA_W = $clog2(NUM_OUT);

   logic                      start;
   logic signed [DATA_W-1:0]  in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic                      w_we;
   logic [WA_W-1:0]           w_addr;
   logic signed [DATA_W-1:0]  w_data;
   logic                      b_we;
   logic [BA_W-1:0]           b_addr;
   logic signed [DATA_W-1:0]  b_data;
   logic [NUM_OUT*DATA_W-1:0] f_fc;
   logic                      over_flag;
   logic                      busy;

   modport master (
      output start, in_data, in_valid, w_we, w_addr, w_data, b_we, b_addr, b_data,
      input  in_ready, f_fc, over_flag, busy
   );
   modport slave (
      input  start, in_data, in_valid, w_we, w_addr, w_data, b_we, b_addr, b_data,
      output in_ready, f_fc, over_flag, busy
   );
endinterface

// File: rtl/fc_layer_seq.sv
// Serial-input FC layer: one feature per handshake MACs into all NUM_OUT accumulators, then bias/rescale/saturate.
// Result and over_flag appear two cycles after the last feature; in_ready is high only while accumulating.
module fc_layer_seq #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int NUM_IN    = 84,
   parameter int NUM_OUT   = 10,
   parameter int ACC_W     = 40
) (
   input logic           clk,
   input logic           rst,
   fc_layer_seq_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_IN);
   localparam int WA_W  = $clog2(NUM_IN*NUM_OUT);
   localparam int BA_W  = $clog2(NUM_OUT);
   localparam int PW    = 2*DATA_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] BIAS  = 2'd2;
   localparam logic [1:0] SAT   = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [ACC_W-1:0]   acc_q [NUM_OUT];
   logic signed [ACC_W-1:0]   acc_d [NUM_OUT];
   logic [NUM_OUT*DATA_W-1:0] f_fc_q, f_fc_d;
   logic                      over_q, over_d;
   logic signed [DATA_W-1:0]  w_q [NUM_IN][NUM_OUT];
   logic signed [DATA_W-1:0]  b_q [NUM_OUT];
   logic                      cfg_en;
   logic signed [PW-1:0]      x_ext, w_ext, prod;
   logic signed [ACC_W-1:0]   sum, shifted;

   assign cfg_en        = (state_q == IDLE);
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.busy      = (state_q != IDLE);
   assign bus.over_flag = over_q;
   assign bus.f_fc      = f_fc_q;

   // Coefficients have no reset so they survive an aborted inference.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (cfg_en && bus.w_we && bus.w_addr == WA_W'(i*NUM_OUT + k))
               w_q[i][k] <= bus.w_data;
         end
      end
      for (int k = 0; k < NUM_OUT; k++) begin
         if (cfg_en && bus.b_we && bus.b_addr == BA_W'(k))
            b_q[k] <= bus.b_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      f_fc_d  = f_fc_q;
      over_d  = 1'b0;
      x_ext   = '0;
      w_ext   = '0;
      prod    = '0;
      sum     = '0;
      shifted = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ACCUM;
               cnt_d   = '0;
               for (int k = 0; k < NUM_OUT; k++) acc_d[k] = '0;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               x_ext = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
               for (int k = 0; k < NUM_OUT; k++) begin
                  w_ext    = {{DATA_W{w_q[cnt_q][k][DATA_W-1]}}, w_q[cnt_q][k]};
                  prod     = x_ext * w_ext;
                  acc_d[k] = acc_q[k] + {{(ACC_W-PW){prod[PW-1]}}, prod};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (32'(cnt_q) == NUM_IN-1) state_d = BIAS;
            end
         end
         // Rescale and saturate are folded into this edge so f_fc is already valid while over_flag is high in SAT.
         BIAS: begin
            for (int k = 0; k < NUM_OUT; k++) begin
               sum      = acc_q[k] + {{(ACC_W-DATA_W-FRAC_BITS){b_q[k][DATA_W-1]}}, b_q[k], {FRAC_BITS{1'b0}}};
               acc_d[k] = sum;
               shifted  = sum >>> FRAC_BITS;
               if (shifted[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){shifted[ACC_W-1]}})
                  f_fc_d[k*DATA_W +: DATA_W] = shifted[DATA_W-1:0];
               else if (shifted[ACC_W-1])
                  f_fc_d[k*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
               else
                  f_fc_d[k*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
            end
            over_d  = 1'b1;
            state_d = SAT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f_fc_q  <= '0;
         over_q  <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) acc_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f_fc_q  <= f_fc_d;
         over_q  <= over_d;
         for (int k = 0; k < NUM_OUT; k++) acc_q[k] <= acc_d[k];
      end
   end
endmodule
